// File: rtl/temp_disp_pkg.sv
// Shared types and constants for the temperature 7-segment display slice:
// conversion FSM encoding, active-low segment codes and BCD sizing.
package temp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int BIN_W      = 20;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [BIN_W-1:0] SAT_MAX = 20'd99_999;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] DP_MASK   = 8'h7F;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = SEG_0;
      4'd1:    c = SEG_1;
      4'd2:    c = SEG_2;
      4'd3:    c = SEG_3;
      4'd4:    c = SEG_4;
      4'd5:    c = SEG_5;
      4'd6:    c = SEG_6;
      4'd7:    c = SEG_7;
      4'd8:    c = SEG_8;
      4'd9:    c = SEG_9;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one iteration per clock, 20 binary bits
// into five BCD digits, with a start/busy/done handshake.
module bin2bcd_seq
  import temp_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  conv_state_t      state;
  logic [4:0]       iter;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb bcd_adj = dabble_adjust(bcd_sr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      iter  <= '0;
    end else begin
      case (state)
        IDLE: begin
          iter <= '0;
          if (start) state <= SHIFT;
        end
        SHIFT: begin
          iter <= iter + 5'd1;
          if (iter == 5'd19) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Shift datapath: loaded on start, adjusted-then-shifted each SHIFT cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      bin_sr <= bin_in;
      bcd_sr <= '0;
    end else if (state == SHIFT) begin
      {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign bcd_out = bcd_sr;

endmodule

// File: rtl/temp_seg_display.sv
// Converts a signed-magnitude temperature (hundredths of a degree) to BCD and
// scans it onto a 6-digit common-anode display as [-]DDD.DD.
module temp_seg_display
  import temp_disp_pkg::*;
#(
  parameter int SCAN_CNT_MAX = 49_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] temp_data,
  input  logic        sign,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int CNT_W = (SCAN_CNT_MAX > 0) ? $clog2(SCAN_CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT_MAX);

  function automatic logic [BIN_W-1:0] sat_value(input logic [BIN_W-1:0] v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  logic             first_pend;
  logic             snap_sign;
  logic [BIN_W-1:0] snap_val;
  logic [BIN_W-1:0] sat_in;
  logic             start;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd;

  logic [3:0]       disp_d [BCD_DIGITS];
  logic             disp_sign;
  logic             mag_nz;

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       scan_idx;
  logic [5:0]       sel_nxt;
  logic [7:0]       seg_nxt;

  // Compare against the saturated value so an over-range input settles instead
  // of retriggering conversions forever.
  assign sat_in = sat_value(temp_data);
  assign start  = !busy && (first_pend || ({sign, sat_in} != {snap_sign, snap_val}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_pend <= 1'b1;
      snap_sign  <= 1'b0;
      snap_val   <= '0;
    end else if (start) begin
      first_pend <= 1'b0;
      snap_sign  <= sign;
      snap_val   <= sat_in;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (sat_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BCD_DIGITS; i++) disp_d[i] <= '0;
      disp_sign <= 1'b0;
    end else if (done) begin
      for (int i = 0; i < BCD_DIGITS; i++) disp_d[i] <= bcd[4*i +: 4];
      disp_sign <= snap_sign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign mag_nz = (disp_d[4] != 4'd0) || (disp_d[3] != 4'd0) || (disp_d[2] != 4'd0) ||
                  (disp_d[1] != 4'd0) || (disp_d[0] != 4'd0);

  always_comb begin
    seg_nxt = SEG_BLANK;
    case (scan_idx)
      3'd5: seg_nxt = (disp_sign && mag_nz) ? SEG_MINUS : SEG_BLANK;
      3'd4: seg_nxt = (disp_d[4] == 4'd0) ? SEG_BLANK : seg_code(disp_d[4]);
      3'd3: seg_nxt = (disp_d[4] == 4'd0 && disp_d[3] == 4'd0) ? SEG_BLANK
                                                                : seg_code(disp_d[3]);
      3'd2: seg_nxt = seg_code(disp_d[2]) & DP_MASK;
      3'd1: seg_nxt = seg_code(disp_d[1]);
      3'd0: seg_nxt = seg_code(disp_d[0]);
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  assign sel_nxt = ~(6'b000001 << scan_idx);

  // Output stage: sel and seg registered together so a digit never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 6'b111111;
      seg <= SEG_BLANK;
    end else begin
      sel <= sel_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_temp_seg_display.sv
// Directed bench for temp_seg_display: captures whole scan frames from sel/seg
// and compares each digit against hand-computed segment codes.
module tb_temp_seg_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] temp_data;
  logic        sign;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame [6];
  logic [7:0] exp_f [6];
  logic [5:0] seen;
  logic       onehot_bad;

  always #5 clk = ~clk;

  temp_seg_display #(.SCAN_CNT_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .temp_data (temp_data),
    .sign      (sign),
    .sel       (sel),
    .seg       (seg)
  );

  task automatic set_exp(input logic [7:0] e5, e4, e3, e2, e1, e0);
    exp_f[5] = e5; exp_f[4] = e4; exp_f[3] = e3;
    exp_f[2] = e2; exp_f[1] = e1; exp_f[0] = e0;
  endtask

  task automatic capture(input int ncyc);
    seen = '0;
    onehot_bad = 1'b0;
    for (int i = 0; i < 6; i++) frame[i] = 8'hXX;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if ($countones(~sel) != 1) onehot_bad = 1'b1;
      else for (int i = 0; i < 6; i++) if (!sel[i]) begin frame[i] = seg; seen[i] = 1'b1; end
    end
  endtask

  task automatic apply(input logic s, input logic [19:0] v);
    @(negedge clk);
    sign = s;
    temp_data = v;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sign = 1'b0; temp_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (sel !== 6'h3F) begin errors++; $display("FAIL reset_sel: got %h, expected 3f", sel); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h, expected ff", seg); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero;
    repeat (24) @(negedge clk);
    capture(26);
    set_exp(8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!seen[i] || frame[i] !== exp_f[i]) begin
        errors++; $display("FAIL zero idx%0d: got %h (seen %b), expected %h", i, frame[i], seen[i], exp_f[i]);
      end
    end
    checks++;
    if (onehot_bad !== 1'b0) begin errors++; $display("FAIL zero_onehot: sel not one-hot"); end
  endtask

  task automatic test_positive;
    apply(1'b0, 20'd2537);
    repeat (24) @(negedge clk);
    capture(26);
    set_exp(8'hFF, 8'hFF, 8'hA4, 8'h12, 8'hB0, 8'hF8);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!seen[i] || frame[i] !== exp_f[i]) begin
        errors++; $display("FAIL pos_2537 idx%0d: got %h (seen %b), expected %h", i, frame[i], seen[i], exp_f[i]);
      end
    end
    checks++;
    if (onehot_bad !== 1'b0) begin errors++; $display("FAIL pos_onehot: sel not one-hot"); end
  endtask

  task automatic test_negative;
    apply(1'b1, 20'd1025);
    repeat (24) @(negedge clk);
    capture(26);
    set_exp(8'hBF, 8'hFF, 8'hF9, 8'h40, 8'hA4, 8'h92);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!seen[i] || frame[i] !== exp_f[i]) begin
        errors++; $display("FAIL neg_1025 idx%0d: got %h (seen %b), expected %h", i, frame[i], seen[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_neg_zero;
    apply(1'b1, 20'd0);
    repeat (24) @(negedge clk);
    capture(26);
    set_exp(8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!seen[i] || frame[i] !== exp_f[i]) begin
        errors++; $display("FAIL neg_zero idx%0d: got %h (seen %b), expected %h", i, frame[i], seen[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_blanking;
    apply(1'b0, 20'd10000);
    repeat (24) @(negedge clk);
    capture(26);
    set_exp(8'hFF, 8'hF9, 8'hC0, 8'h40, 8'hC0, 8'hC0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!seen[i] || frame[i] !== exp_f[i]) begin
        errors++; $display("FAIL blank_10000 idx%0d: got %h (seen %b), expected %h", i, frame[i], seen[i], exp_f[i]);
      end
    end
    apply(1'b1, 20'd5);
    repeat (24) @(negedge clk);
    capture(26);
    set_exp(8'hBF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h92);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!seen[i] || frame[i] !== exp_f[i]) begin
        errors++; $display("FAIL blank_neg5 idx%0d: got %h (seen %b), expected %h", i, frame[i], seen[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_saturate;
    apply(1'b0, 20'd200_000);
    repeat (24) @(negedge clk);
    capture(26);
    set_exp(8'hFF, 8'h90, 8'h90, 8'h10, 8'h90, 8'h90);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!seen[i] || frame[i] !== exp_f[i]) begin
        errors++; $display("FAIL sat idx%0d: got %h (seen %b), expected %h", i, frame[i], seen[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    apply(1'b0, 20'd2537);
    repeat (6) @(posedge clk);
    @(negedge clk);
    temp_data = 20'd1250;
    repeat (16) @(negedge clk);
    capture(20);
    set_exp(8'hFF, 8'hFF, 8'hA4, 8'h12, 8'hB0, 8'hF8);
    checks++;
    if ($countones(seen) < 3) begin errors++; $display("FAIL b2b_first_window: digits seen %b, expected at least 3", seen); end
    for (int i = 0; i < 6; i++) begin
      if (seen[i]) begin
        checks++;
        if (frame[i] !== exp_f[i]) begin
          errors++; $display("FAIL b2b_first idx%0d: got %h, expected %h", i, frame[i], exp_f[i]);
        end
      end
    end
    repeat (9) @(negedge clk);
    capture(26);
    set_exp(8'hFF, 8'hFF, 8'hF9, 8'h24, 8'h92, 8'hC0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!seen[i] || frame[i] !== exp_f[i]) begin
        errors++; $display("FAIL b2b_second idx%0d: got %h (seen %b), expected %h", i, frame[i], seen[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    apply(1'b0, 20'd4321);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 6'h3F) begin errors++; $display("FAIL midrst_sel: got %h, expected 3f", sel); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL midrst_seg: got %h, expected ff", seg); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) @(negedge clk);
    capture(26);
    set_exp(8'hFF, 8'hFF, 8'h99, 8'h30, 8'hA4, 8'hF9);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!seen[i] || frame[i] !== exp_f[i]) begin
        errors++; $display("FAIL midrst_4321 idx%0d: got %h (seen %b), expected %h", i, frame[i], seen[i], exp_f[i]);
      end
    end
    checks++;
    if (onehot_bad !== 1'b0) begin errors++; $display("FAIL midrst_onehot: sel not one-hot"); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_positive;
    test_negative;
    test_neg_zero;
    test_blanking;
    test_saturate;
    test_back_to_back;
    test_reset_mid_shift;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
